// File: rtl/tube_pkg.sv
// Shared constants for the Tube host-side register interface: register
// indices, status byte layout and control flag positions.
package tube_pkg;

    localparam int NUM_REGS = 4;
    localparam int FLAG_W   = 6;

    localparam logic [1:0] REG_R1 = 2'd0;
    localparam logic [1:0] REG_R2 = 2'd1;
    localparam logic [1:0] REG_R3 = 2'd2;
    localparam logic [1:0] REG_R4 = 2'd3;

    // Status byte: N = data available (host side), F = room in host-to-parasite FIFO
    localparam int STAT_N_BIT = 7;
    localparam int STAT_F_BIT = 6;

    localparam int FLAG_I = 0;
    localparam int FLAG_J = 1;

    // R4 data drives IRQ, R3 data drives NMI
    localparam int IRQ_REG = 3;
    localparam int NMI_REG = 2;

    localparam logic [2:0] ADDR_CTRL = 3'b000;

endpackage

// File: rtl/tube_access_detect.sv
// Detects the start of a host access: first low cycle of h_cs_b after a high
// cycle. The history flop resets low so an access spanning reset is ignored.
module tube_access_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cs_b_i,
    output logic start_o
);

    logic cs_b_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) cs_b_q <= 1'b0;
        else       cs_b_q <= cs_b_i;
    end

    assign start_o = cs_b_q & ~cs_b_i & ~rst_i;

endmodule

// File: rtl/tube_host_regif.sv
// Host-side register interface of the Tube: decodes host accesses into FIFO
// select/read/write strobes, serves status bytes and owns the control flags.
module tube_host_regif
    import tube_pkg::*;
#(
    parameter logic [FLAG_W-1:0] CTRL_RESET = 6'b000000
) (
    input  logic                h_phi2,
    input  logic                h_rst,
    input  logic                h_cs_b,
    input  logic                h_rdnw,
    input  logic [2:0]          h_addr,
    input  logic [7:0]          h_din,
    output logic [7:0]          h_dout,
    output logic [NUM_REGS-1:0] h_selectData,
    output logic                h_rd,
    output logic                h_we,
    input  logic [7:0]          ph_data,
    input  logic [NUM_REGS-1:0] ph_data_available,
    input  logic [NUM_REGS-1:0] hp_full,
    output logic [FLAG_W-1:0]   ctrl_flags,
    output logic                h_irq_b,
    output logic                h_nmi_b
);

    logic              start;
    logic              rd_start, wr_start;
    logic [1:0]        reg_n;
    logic              is_data;
    logic [7:0]        stat_byte;
    logic [7:0]        dout_q, dout_d;
    logic [FLAG_W-1:0] ctrl_q, ctrl_d;
    logic              irq_b_q, nmi_b_q;
    logic              unused_din6;

    tube_access_detect u_detect (
        .clk_i   (h_phi2),
        .rst_i   (h_rst),
        .cs_b_i  (h_cs_b),
        .start_o (start)
    );

    assign reg_n       = h_addr[2:1];
    assign is_data     = h_addr[0];
    assign rd_start    = start &  h_rdnw;
    assign wr_start    = start & ~h_rdnw;
    assign unused_din6 = h_din[6];

    always_comb begin
        h_selectData = '0;
        if (!h_cs_b) h_selectData[reg_n] = 1'b1;
    end

    // Strobes are combinational so the FIFOs see them in the access-start cycle
    assign h_rd = rd_start &  is_data;
    assign h_we = wr_start &  is_data;

    always_comb begin
        stat_byte             = 8'hFF;
        stat_byte[STAT_N_BIT] = ph_data_available[reg_n];
        stat_byte[STAT_F_BIT] = ~hp_full[reg_n];
        if (reg_n == REG_R1) stat_byte[FLAG_W-1:0] = ctrl_q;
    end

    always_comb begin
        dout_d = dout_q;
        if (rd_start) dout_d = is_data ? ph_data : stat_byte;
    end

    // h_din[7] selects set vs clear; h_din[5:0] is the bit mask
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_start && h_addr == ADDR_CTRL) begin
            if (h_din[7]) ctrl_d = ctrl_q |  h_din[FLAG_W-1:0];
            else          ctrl_d = ctrl_q & ~h_din[FLAG_W-1:0];
        end
    end

    always_ff @(posedge h_phi2) begin
        if (h_rst) begin
            dout_q  <= 8'h00;
            ctrl_q  <= CTRL_RESET;
            irq_b_q <= 1'b1;
            nmi_b_q <= 1'b1;
        end else begin
            dout_q  <= dout_d;
            ctrl_q  <= ctrl_d;
            irq_b_q <= ~(ctrl_q[FLAG_I] & ph_data_available[IRQ_REG]);
            nmi_b_q <= ~(ctrl_q[FLAG_J] & ph_data_available[NMI_REG]);
        end
    end

    assign h_dout     = dout_q;
    assign ctrl_flags = ctrl_q;
    assign h_irq_b    = irq_b_q;
    assign h_nmi_b    = nmi_b_q;

endmodule

// File: doc/tube_host_regif.md
TUBE_HOST_REGIF -- requirements
Module: tube_host_regif

Interface
REQ-001 SHALL have parameter CTRL_RESET, default 6'b000000, reset value of control flags.
REQ-002 SHALL have port h_phi2  in  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port h_rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port h_cs_b  in  1  host chip select, active low.
REQ-005 SHALL have port h_rdnw  in  1  1=read, 0=write; sampled with h_cs_b.
REQ-006 SHALL have port h_addr  in  3  register address; [2:1]=register n (0..3), [0]=1 data, 0 status.
REQ-007 SHALL have port h_din  in  8  host write data.
REQ-008 SHALL have port h_dout  out  8  registered host read data.
REQ-009 SHALL have port h_selectData  out  4  one-hot register select to the parasite-to-host FIFO quad and host-to-parasite FIFOs.
REQ-010 SHALL have port h_rd  out  1  one-cycle read-advance pulse to the parasite-to-host FIFO quad.
REQ-011 SHALL have port h_we  out  1  one-cycle write pulse to the host-to-parasite FIFOs.
REQ-012 SHALL have port ph_data  in  8  selected FIFO byte from the parasite-to-host FIFO quad.
REQ-013 SHALL have port ph_data_available  in  4  per-register data-available flags.
REQ-014 SHALL have port hp_full  in  4  per-register host-to-parasite full flags.
REQ-015 SHALL have port ctrl_flags  out  6  control flags; bit0 I (IRQ enable), bit1 J (NMI enable), bits 5:2 general.
REQ-016 SHALL have port h_irq_b  out  1  host interrupt, active low.
REQ-017 SHALL have port h_nmi_b  out  1  host NMI, active low.

Function
REQ-018 Access start SHALL be the first cycle with h_cs_b=0 after a cycle with h_cs_b=1; it SHALL be recognised exactly once per access, however long h_cs_b stays low.
REQ-019 h_selectData SHALL be one-hot decode of h_addr[2:1] while h_cs_b=0, and 4'b0000 otherwise (combinational).
REQ-020 Read of a data address SHALL capture ph_data into h_dout and assert h_rd, both in the access-start cycle; h_dout is valid 1 cycle later.
REQ-021 Read of status register n SHALL load h_dout={ph_data_available[n], ~hp_full[n], L} in the access-start cycle, where L=ctrl_flags for n=0 and 6'b111111 otherwise.
REQ-022 h_dout SHALL hold its value until the next read access start.
REQ-023 Write to address 0 SHALL update ctrl_flags on access start: h_din[7]=1 sets the bits selected by h_din[5:0]; h_din[7]=0 clears them. Unselected bits hold.
REQ-024 Write to a data address SHALL assert h_we for exactly the access-start cycle.
REQ-025 Writes to status addresses 2, 4 and 6 SHALL be ignored.
REQ-026 Read of an empty data register SHALL still pulse h_rd; underflow handling belongs to the FIFO.
REQ-027 h_rd and h_we SHALL never be high in the same cycle.
REQ-028 h_irq_b SHALL be registered: next value = ~(ctrl_flags[0] & ph_data_available[3]).
REQ-029 h_nmi_b SHALL be registered: next value = ~(ctrl_flags[1] & ph_data_available[2]).
REQ-030 A write to address 0 that changes I or J SHALL affect h_irq_b/h_nmi_b one cycle after ctrl_flags updates.
REQ-031 h_cs_b deasserted for one cycle then reasserted SHALL produce a new access start.

Reset
REQ-032 With h_rst=1, the block SHALL reset to: h_dout=8'h00, h_rd=0, h_we=0, ctrl_flags=CTRL_RESET, h_irq_b=1, h_nmi_b=1.
REQ-033 The registered previous h_cs_b SHALL reset to 0, so an access in progress across reset release is not recognised.
REQ-034 Reset SHALL override any simultaneous access.

Structure
REQ-035 Package tube_pkg SHALL hold the register index constants, status bit positions (N=7, F=6) and control flag bit positions.
REQ-036 Access-start edge detection SHALL be one sub-module, tube_access_detect; all else is inline.

Verification
REQ-037 The bench SHALL cover: ph_data=8'hA5, ph_data_available[0]=1, read addr 1 -> one h_rd pulse, h_dout=8'hA5 next cycle, selectData=4'b0001.
REQ-038 The bench SHALL cover: write 8'h81, then 8'h82, then 8'h01 to addr 0 -> ctrl_flags 6'h01, 6'h03, 6'h02.
REQ-039 The bench SHALL cover: ph_data_available[1]=0, hp_full[1]=0, read addr 2 -> h_dout=8'h7F, no h_rd.
REQ-040 The bench SHALL cover: flags I=1, ph_data_available[3] rises -> h_irq_b low one cycle later; clear I -> h_irq_b high.
REQ-041 The bench SHALL cover: h_cs_b held low 5 cycles on write addr 7 -> single h_we, selectData=4'b1000.
REQ-042 The bench SHALL cover: h_rst during an active read with h_cs_b low -> outputs at reset values; no h_rd after release until h_cs_b toggles.
